// File: rtl/fetch_stage_pkg.sv
// Shared LEGv8 fetch constants: instruction field positions, PC step and FSM encoding.
package fetch_stage_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 21;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int PC_INC     = 4;

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter: reset load, sequential increment, and a redirect that wins over increment.
module fetch_stage_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              incEn,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  // Branch targets are forced word-aligned; increment wraps modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target & ~ADDR_W'(3);
    end else if (incEn) begin
      pc <= pc + ADDR_W'(PC_INC);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch: single outstanding imem read, output latch towards decode,
// and branch redirect that squashes whatever fetch is in flight.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [OPCODE_W-1:0] if_opcode,
  output logic [ADDR_W-1:0]   if_pc,
  input  logic                br_taken,
  input  logic [ADDR_W-1:0]   br_target
);

  logic [1:0]        state;
  logic              drop;
  logic [ADDR_W-1:0] pc;
  logic              acceptRsp;

  assign acceptRsp = (state == ST_WAIT) && imem_rvalid && !drop;

  fetch_stage_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) uPcReg (
    .clk      (clk),
    .rst_n    (rst_n),
    .incEn    (acceptRsp),
    .redirect (br_taken),
    .target   (br_target),
    .pc       (pc)
  );

  assign imem_req  = (state == ST_REQ);
  assign imem_addr = pc;
  assign if_opcode = if_instr[OPCODE_MSB:OPCODE_LSB];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_REQ;
      drop     <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (br_taken) begin
      // A request already accepted at the old PC still owes a response; mark it for discard.
      if_valid <= 1'b0;
      case (state)
        ST_REQ: begin
          if (imem_ready) begin
            state <= ST_WAIT;
            drop  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            state <= ST_REQ;
            drop  <= 1'b0;
          end else begin
            drop <= 1'b1;
          end
        end
        default: state <= ST_REQ;
      endcase
    end else begin
      case (state)
        ST_REQ: begin
          if (imem_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= ST_REQ;
            end else begin
              if_instr <= imem_rdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
              state    <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (if_ready) begin
            if_valid <= 1'b0;
            state    <= ST_REQ;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: behavioural imem with programmable latency and a
// scoreboard monitor that checks every instruction accepted by the decode side.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [10:0] if_opcode;
  logic [63:0] if_pc;
  logic        br_taken;
  logic [63:0] br_target;

  int nChecks = 0;
  int nFail   = 0;
  int memLat  = 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [10:0] opcode;
    logic [63:0] pc;
  } exp_t;

  exp_t expQ[$];

  fetch_stage #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_opcode   (if_opcode),
    .if_pc       (if_pc),
    .br_taken    (br_taken),
    .br_target   (br_target)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [63:0] a);
    case (a)
      64'h0:                   memData = 32'h8B020020;
      64'h4:                   memData = 32'hF8400041;
      64'h8:                   memData = 32'hAA0103E2;
      64'h100:                 memData = 32'hB4000040;
      64'h104:                 memData = 32'h91000421;
      64'h200:                 memData = 32'hCB020020;
      64'hFFFF_FFFF_FFFF_FFFC: memData = 32'hD65F03C0;
      default:                 memData = {16'hDEAD, a[15:0]};
    endcase
  endfunction

  // Instruction memory: answers memLat cycles after an accepted request, reset with rst_n.
  logic        memAcc, memRst, memPend;
  logic [63:0] memA, memPAddr;
  int          memCnt;
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    memPend     = 1'b0;
    memCnt      = 0;
    memPAddr    = '0;
  end
  always @(posedge clk) begin
    memAcc = imem_req && imem_ready;
    memRst = !rst_n;
    memA   = imem_addr;
    #1;
    imem_rvalid = 1'b0;
    if (memRst) begin
      memPend = 1'b0;
    end else begin
      if (memAcc) begin
        memPend  = 1'b1;
        memCnt   = memLat;
        memPAddr = memA;
      end
      if (memPend) begin
        if (memCnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memData(memPAddr);
          memPend     = 1'b0;
        end else begin
          memCnt = memCnt - 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nChecks++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeoutFail(input string name);
    nChecks++;
    nFail++;
    $display("FAIL %s: bound expired, actual=timeout required=event", name);
  endtask

  task automatic pushExp(input logic [31:0] instr, input logic [10:0] opc, input logic [63:0] pc);
    exp_t e;
    e.instr  = instr;
    e.opcode = opc;
    e.pc     = pc;
    expQ.push_back(e);
  endtask

  task automatic waitReq();
    int n = 0;
    while (!imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) timeoutFail("waitReq");
  endtask

  task automatic waitNotReq();
    int n = 0;
    while (imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) timeoutFail("waitNotReq");
  endtask

  task automatic nextReq();
    waitNotReq();
    waitReq();
  endtask

  task automatic waitOut();
    int n = 0;
    while (!if_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) timeoutFail("waitOut");
  endtask

  // Scoreboard monitor: stimulus changes at the falling edge, so sample just after it.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst_n && if_valid && if_ready && !br_taken) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFail++;
        $display("FAIL sb_unexpected: actual instr=%0h pc=%0h required=none", if_instr, if_pc);
      end else begin
        e = expQ.pop_front();
        check("sb_instr", 64'(if_instr), 64'(e.instr));
        check("sb_opcode", 64'(if_opcode), 64'(e.opcode));
        check("sb_pc", if_pc, e.pc);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    imem_ready = 1'b1;
    if_ready   = 1'b1;
    br_taken   = 1'b0;
    br_target  = '0;
    memLat     = 1;

    // Reset state and first fetch at RESET_PC
    repeat (2) @(negedge clk);
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_imem_req", 64'(imem_req), 64'd1);
    check("rst_imem_addr", imem_addr, 64'h0);
    rst_n = 1'b1;
    pushExp(32'h8B020020, 11'h458, 64'h0);
    @(negedge clk);
    check("wait_req_low", 64'(imem_req), 64'd0);
    @(negedge clk);
    check("first_valid", 64'(if_valid), 64'd1);
    check("first_opcode", 64'(if_opcode), 64'h458);
    check("first_pc", if_pc, 64'h0);
    @(negedge clk);
    check("next_addr_4", imem_addr, 64'h4);
    check("next_req", 64'(imem_req), 64'd1);

    // Downstream stall holds the output stable and blocks further requests
    if_ready = 1'b0;
    pushExp(32'hF8400041, 11'h7C2, 64'h4);
    waitOut();
    for (int i = 0; i < 6; i++) begin
      check("stall_valid", 64'(if_valid), 64'd1);
      check("stall_instr", 64'(if_instr), 64'hF8400041);
      check("stall_opcode", 64'(if_opcode), 64'h7C2);
      check("stall_pc", if_pc, 64'h4);
      check("stall_no_req", 64'(imem_req), 64'd0);
      if (i < 5) @(negedge clk);
    end
    if_ready = 1'b1;
    @(negedge clk);
    check("after_stall_req", 64'(imem_req), 64'd1);
    check("after_stall_addr", imem_addr, 64'h8);

    // Redirect while waiting on a slow response: response dropped, refetch at aligned target
    memLat = 3;
    @(negedge clk);
    check("in_wait", 64'(imem_req), 64'd0);
    br_taken  = 1'b1;
    br_target = 64'h103;
    @(negedge clk);
    br_taken = 1'b0;
    waitReq();
    check("wait_redirect_addr", imem_addr, 64'h100);

    // Redirect in OUT together with if_ready squashes the held instruction
    memLat   = 1;
    if_ready = 1'b0;
    waitOut();
    check("out_instr", 64'(if_instr), 64'hB4000040);
    check("out_opcode", 64'(if_opcode), 64'h5A0);
    check("out_pc", if_pc, 64'h100);
    br_taken  = 1'b1;
    br_target = 64'h200;
    if_ready  = 1'b1;
    @(negedge clk);
    br_taken = 1'b0;
    check("squash_valid", 64'(if_valid), 64'd0);
    check("squash_req", 64'(imem_req), 64'd1);
    check("squash_addr", imem_addr, 64'h200);
    pushExp(32'hCB020020, 11'h658, 64'h200);
    nextReq();
    check("after_200_addr", imem_addr, 64'h204);

    // Redirect in REQ while memory accepts: stale response dropped
    br_taken  = 1'b1;
    br_target = 64'h104;
    @(negedge clk);
    br_taken = 1'b0;
    check("req_acc_wait", 64'(imem_req), 64'd0);
    waitReq();
    check("req_acc_redirect_addr", imem_addr, 64'h104);
    pushExp(32'h91000421, 11'h488, 64'h104);
    nextReq();
    check("after_104_addr", imem_addr, 64'h108);

    // Redirect in REQ while memory stalls: request simply moves to the new PC
    imem_ready = 1'b0;
    br_taken   = 1'b1;
    br_target  = 64'h8;
    @(negedge clk);
    br_taken = 1'b0;
    check("req_stall_req", 64'(imem_req), 64'd1);
    check("req_stall_addr", imem_addr, 64'h8);
    imem_ready = 1'b1;
    pushExp(32'hAA0103E2, 11'h550, 64'h8);
    nextReq();
    check("after_8_addr", imem_addr, 64'hC);

    // PC wrap from the top word, reached via an unaligned all-ones target
    imem_ready = 1'b0;
    br_taken   = 1'b1;
    br_target  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    br_taken   = 1'b0;
    imem_ready = 1'b1;
    check("top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    pushExp(32'hD65F03C0, 11'h6B2, 64'hFFFF_FFFF_FFFF_FFFC);
    nextReq();
    check("wrap_addr", imem_addr, 64'h0);

    // Reset while an instruction is held in OUT
    if_ready = 1'b0;
    waitOut();
    check("held_before_rst", 64'(if_instr), 64'h8B020020);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(if_valid), 64'd0);
    check("rst_out_req", 64'(imem_req), 64'd1);
    check("rst_out_addr", imem_addr, 64'h0);
    rst_n    = 1'b1;
    if_ready = 1'b1;
    pushExp(32'h8B020020, 11'h458, 64'h0);
    nextReq();
    check("post_rst_addr", imem_addr, 64'h4);
    repeat (2) @(negedge clk);
    check("sb_drained", 64'(expQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
